// File: rtl/aes_pkg.sv
// Shared types and constants for the AES result byte scanner.
// Scanner state encoding and byte/BCD geometry.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    HOLD
  } scan_state_t;

  localparam int NUM_BYTES = 16;
  localparam int BYTE_W    = 8;
  localparam int BCD_W     = 12;
  localparam int BCD_ITER  = 8;

endpackage

// File: rtl/bcd_serial_converter.sv
// Sequential 8-bit binary to 3-digit BCD converter (double-dabble).
// Ports: clk, reset (async, active-high); start/bin launch a conversion;
// busy = iterations 2..8 pending; done/result valid in the cycle whose
// closing edge performs the 8th iteration.
module bcd_serial_converter
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [BYTE_W-1:0] bin,
  output logic              busy,
  output logic              done,
  output logic [BCD_W-1:0]  result
);

  logic [19:0] work;
  logic [19:0] src;
  logic [19:0] adj;
  logic [19:0] step;
  logic [2:0]  cnt;
  logic        busy_q;
  logic        active;
  logic        last;

  // The first iteration works straight off bin, so a conversion
  // takes exactly BCD_ITER edges counting the start edge.
  always_comb begin
    src = busy_q ? work : {12'd0, bin};
    adj = src;
    for (int i = 0; i < 3; i++) begin
      if (src[8+4*i +: 4] >= 4'd5)
        adj[8+4*i +: 4] = src[8+4*i +: 4] + 4'd3;
    end
    step = {adj[18:0], 1'b0};
  end

  assign active = start | busy_q;
  assign last   = active && (cnt == 3'(BCD_ITER - 1));
  assign busy   = busy_q;
  assign done   = last;
  assign result = step[19:8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work   <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
    end else if (active) begin
      work   <= step;
      cnt    <= cnt + 3'd1;
      busy_q <= !last;
    end
  end

endmodule

// File: rtl/aes_result_byte_scanner.sv
// Walks a captured 128-bit AES result byte by byte (MSB byte first),
// converts each byte to BCD and holds it for DWELL_CYCLES clocks.
// Ports: clk, reset (async, active-high); in_block/in_valid/in_ready
// handshake; byte_idx/byte_out/bcd_out/bcd_valid display feed; done
// pulses once after the final byte of a non-looping scan.
module aes_result_byte_scanner
  import aes_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 25_000_000,
  parameter bit          LOOP         = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_BYTES*8-1:0]   in_block,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [3:0]               byte_idx,
  output logic [BYTE_W-1:0]        byte_out,
  output logic [BCD_W-1:0]         bcd_out,
  output logic                     bcd_valid,
  output logic                     done
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_BYTES - 1);

  scan_state_t state;
  scan_state_t state_n;

  logic [NUM_BYTES*8-1:0] blk;
  logic [NUM_BYTES*8-1:0] blk_sh;
  logic [31:0]            dwell;
  logic                   accept;
  logic                   dwell_end;
  logic                   conv_start;
  logic                   conv_busy;
  logic                   conv_done;
  logic [BCD_W-1:0]       conv_result;

  assign in_ready  = (state == IDLE) ||
                     (LOOP && (state == HOLD));
  assign accept    = in_valid && in_ready;
  assign dwell_end = (dwell == 32'(DWELL_CYCLES - 1));

  // Byte mux: shifting byte_idx bytes left brings it to the top.
  always_comb begin
    blk_sh   = blk << {byte_idx, 3'b000};
    byte_out = blk_sh[NUM_BYTES*8-1 -: BYTE_W];
  end

  bcd_serial_converter u_conv (
    .clk    (clk),
    .reset  (reset),
    .start  (conv_start),
    .bin    (byte_out),
    .busy   (conv_busy),
    .done   (conv_done),
    .result (conv_result)
  );

  always_comb begin
    state_n    = state;
    conv_start = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_n = CONVERT;
      end
      CONVERT: begin
        conv_start = !conv_busy;
        if (conv_done) state_n = HOLD;
      end
      HOLD: begin
        // A new block wins over dwell expiry.
        if (accept)
          state_n = CONVERT;
        else if (dwell_end)
          state_n = (byte_idx != LAST_IDX || LOOP) ?
                    CONVERT : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blk       <= '0;
      byte_idx  <= '0;
      bcd_out   <= '0;
      bcd_valid <= 1'b0;
      done      <= 1'b0;
      dwell     <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        blk       <= in_block;
        byte_idx  <= '0;
        bcd_valid <= 1'b0;
      end else if (state == CONVERT) begin
        if (conv_done) begin
          bcd_out   <= conv_result;
          bcd_valid <= 1'b1;
          dwell     <= '0;
        end
      end else if (state == HOLD) begin
        dwell <= dwell + 32'd1;
        if (dwell_end) begin
          if (byte_idx != LAST_IDX) begin
            byte_idx  <= byte_idx + 4'd1;
            bcd_valid <= 1'b0;
          end else if (LOOP) begin
            byte_idx  <= '0;
            bcd_valid <= 1'b0;
          end else begin
            done <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_result_byte_scanner.sv
// Directed + randomized bench for aes_result_byte_scanner.
// Non-loop and loop instances, both with a dwell of 4 cycles.
module tb_aes_result_byte_scanner;

  localparam int DW = 4;

  logic         clk = 1'b0;
  logic         rst0, rst1;
  logic [127:0] blk0, blk1;
  logic         vld0, vld1;
  logic         rdy0, rdy1;
  logic [3:0]   idx0, idx1;
  logic [7:0]   byt0, byt1;
  logic [11:0]  bcd0, bcd1;
  logic         bv0, bv1;
  logic         dn0, dn1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes_result_byte_scanner #(.DWELL_CYCLES(DW), .LOOP(1'b0)) dut0 (
    .clk(clk), .reset(rst0), .in_block(blk0), .in_valid(vld0),
    .in_ready(rdy0), .byte_idx(idx0), .byte_out(byt0),
    .bcd_out(bcd0), .bcd_valid(bv0), .done(dn0)
  );

  aes_result_byte_scanner #(.DWELL_CYCLES(DW), .LOOP(1'b1)) dut1 (
    .clk(clk), .reset(rst1), .in_block(blk1), .in_valid(vld1),
    .in_ready(rdy1), .byte_idx(idx1), .byte_out(byt1),
    .bcd_out(bcd1), .bcd_valid(bv1), .done(dn1)
  );

  function automatic logic [7:0] byte_of(logic [127:0] b, int k);
    return b[127-8*k -: 8];
  endfunction

  function automatic logic [11:0] bcd_of(logic [7:0] v);
    int h, t, o;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    return {4'(h), 4'(t), 4'(o)};
  endfunction

  function automatic logic [127:0] rnd_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk0(string tag, logic [127:0] b, int k, logic v);
    chk({tag, " idx"}, 32'(idx0), 32'(k));
    chk({tag, " byte"}, 32'(byt0), 32'(byte_of(b, k)));
    if (v) chk({tag, " bcd"}, 32'(bcd0), 32'(bcd_of(byte_of(b, k))));
    chk({tag, " valid"}, 32'(bv0), 32'(v));
  endtask

  task automatic chk1(string tag, logic [127:0] b, int k, logic v);
    chk({tag, " idx"}, 32'(idx1), 32'(k));
    chk({tag, " byte"}, 32'(byt1), 32'(byte_of(b, k)));
    if (v) chk({tag, " bcd"}, 32'(bcd1), 32'(bcd_of(byte_of(b, k))));
    chk({tag, " valid"}, 32'(bv1), 32'(v));
    chk({tag, " done"}, 32'(dn1), 32'd0);
  endtask

  logic [127:0] va, vb;

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    vld0 = 1'b0; vld1 = 1'b0;
    blk0 = '0;   blk1 = '0;
    tick(2);
    rst0 = 1'b0;

    // Reset state
    chk("rst ready", 32'(rdy0), 32'd1);
    chk("rst idx", 32'(idx0), 32'd0);
    chk("rst byte", 32'(byt0), 32'd0);
    chk("rst bcd", 32'(bcd0), 32'd0);
    chk("rst valid", 32'(bv0), 32'd0);
    chk("rst done", 32'(dn0), 32'd0);

    // Reference vector, full non-looping scan
    va = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    blk0 = va; vld0 = 1'b1;
    tick(1);
    vld0 = 1'b0;
    chk("e0 ready", 32'(rdy0), 32'd0);
    chk0("e0", va, 0, 1'b0);
    tick(7);
    chk("e7 valid", 32'(bv0), 32'd0);
    tick(1);
    chk("e8 bcd const", 32'(bcd0), 32'h105);
    for (int k = 0; k < 16; k++) begin
      chk0("scan", va, k, 1'b1);
      chk("scan ready", 32'(rdy0), 32'd0);
      chk("scan done", 32'(dn0), 32'd0);
      if (k == 1) chk("e20 bcd const", 32'(bcd0), 32'h196);
      if (k == 15) chk("e188 bcd const", 32'(bcd0), 32'h090);
      tick(DW);
      if (k < 15) begin
        chk0("dwell exit", va, k + 1, 1'b0);
        tick(8);
      end
    end
    chk("end done", 32'(dn0), 32'd1);
    chk("end ready", 32'(rdy0), 32'd1);
    chk0("end", va, 15, 1'b1);
    tick(1);
    chk("end done clr", 32'(dn0), 32'd0);
    chk("end valid", 32'(bv0), 32'd1);

    // Boundary: byte 0 = 00
    va = rnd_block();
    va[127:120] = 8'h00;
    blk0 = va; vld0 = 1'b1;
    tick(1);
    vld0 = 1'b0;
    tick(8);
    chk("b00 bcd", 32'(bcd0), 32'h000);
    chk0("b00", va, 0, 1'b1);

    // Boundary: byte 0 = ff (after async reset)
    rst0 = 1'b1; #1; rst0 = 1'b0;
    va = rnd_block();
    va[127:120] = 8'hff;
    blk0 = va; vld0 = 1'b1;
    tick(1);
    vld0 = 1'b0;
    tick(8);
    chk("bff bcd", 32'(bcd0), 32'h255);
    chk0("bff", va, 0, 1'b1);

    // Reset during CONVERT of byte 3; held in_valid ignored
    rst0 = 1'b1; #1; rst0 = 1'b0;
    va = rnd_block();
    blk0 = va; vld0 = 1'b1;
    tick(1);
    vld0 = 1'b0;
    tick(36 + 3);
    chk0("cv3", va, 3, 1'b0);
    blk0 = rnd_block(); vld0 = 1'b1;
    tick(2);
    chk("cv3 ready", 32'(rdy0), 32'd0);
    chk0("cv3 held", va, 3, 1'b0);
    rst0 = 1'b1;
    #1;
    chk("mid rst ready", 32'(rdy0), 32'd1);
    chk("mid rst idx", 32'(idx0), 32'd0);
    chk("mid rst byte", 32'(byt0), 32'd0);
    chk("mid rst bcd", 32'(bcd0), 32'd0);
    chk("mid rst valid", 32'(bv0), 32'd0);
    chk("mid rst done", 32'(dn0), 32'd0);
    vld0 = 1'b0;
    rst0 = 1'b0;

    // LOOP=1: wrap without done, then restart during byte 7 HOLD
    rst1 = 1'b0;
    va = rnd_block();
    blk1 = va; vld1 = 1'b1;
    tick(1);
    vld1 = 1'b0;
    tick(8);
    for (int k = 0; k < 16; k++) begin
      chk1("loop", va, k, 1'b1);
      tick(DW);
      chk1("loop exit", va, (k + 1) % 16, 1'b0);
      tick(8);
    end
    chk1("wrap", va, 0, 1'b1);
    tick(12 * 7);
    chk1("pass2 b7", va, 7, 1'b1);
    tick(1);
    chk("hold ready", 32'(rdy1), 32'd1);
    vb = rnd_block();
    blk1 = vb; vld1 = 1'b1;
    tick(1);
    vld1 = 1'b0;
    chk1("restart", vb, 0, 1'b0);
    chk("restart ready", 32'(rdy1), 32'd0);
    tick(8);
    chk1("new b0", vb, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
